// File: rtl/sccb_target_responder_if.sv
// Host-side view of the SCCB target responder: register-map inspection plus
// committed-write and transaction status.
interface sccb_target_responder_if;
  logic [7:0] host_addr;
  logic [7:0] host_rdata;
  logic       reg_wr;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] sub_addr;
  logic       busy;
  logic       txn_abort;

  modport master (
    output host_addr,
    input  host_rdata,
    input  reg_wr,
    input  reg_wr_addr,
    input  reg_wr_data,
    input  sub_addr,
    input  busy,
    input  txn_abort
  );

  modport slave (
    input  host_addr,
    output host_rdata,
    output reg_wr,
    output reg_wr_addr,
    output reg_wr_data,
    output sub_addr,
    output busy,
    output txn_abort
  );
endinterface

// File: rtl/sccb_target_responder.sv
// SCCB camera-side target with a 256x8 register map. Oversamples SIOC/SIOD on xclk,
// decodes START/STOP, 3-phase write, 2-phase write and 2-phase read.
module sccb_target_responder #(
  parameter logic [7:0]  DEVICE_ID   = 8'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    xclk,
  input  logic                    resetn,
  input  logic                    sioc,
  inout  wire                     siod,
  sccb_target_responder_if.slave  host
);

  typedef enum logic [3:0] {
    StIdle,
    StId,
    StIdAck,
    StSub,
    StSubAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdNa,
    StIgnore
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sioc_sync_q;
  logic [SYNC_STAGES-1:0] siod_sync_q;
  logic                   sioc_prev_q;
  logic                   siod_prev_q;
  logic [7:0]             regs_q [256];
  logic [7:0]             shreg_q;
  logic [7:0]             sub_addr_q;
  logic [7:0]             wr_addr_q;
  logic [7:0]             wr_data_q;
  logic [3:0]             bit_cnt_q;
  logic                   bit_pend_q;
  logic                   drive_en_q;
  logic                   drive_val_q;
  logic                   busy_q;
  logic                   abort_q;
  logic                   wr_q;

  logic       sioc_s;
  logic       siod_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_ev;
  logic       stop_ev;
  logic       mid_byte;
  logic [7:0] shreg_in;

  assign sioc_s   = sioc_sync_q[SYNC_STAGES-1];
  assign siod_s   = siod_sync_q[SYNC_STAGES-1];
  assign scl_rise = sioc_s & ~sioc_prev_q;
  assign scl_fall = ~sioc_s & sioc_prev_q;
  // Our own drive transitions must never be mistaken for bus conditions.
  assign start_ev = ~drive_en_q & sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
  assign stop_ev  = ~drive_en_q & sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
  assign mid_byte = (bit_cnt_q != 4'd0) && (bit_cnt_q < 4'd8);
  assign shreg_in = {shreg_q[6:0], siod_s};

  // Synchronisers reset to the idle-high bus level so no edge is seen after reset.
  always_ff @(posedge xclk or negedge resetn) begin
    if (!resetn) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
    end else begin
      sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc};
      siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod};
      sioc_prev_q <= sioc_s;
      siod_prev_q <= siod_s;
    end
  end

  always_ff @(posedge xclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      shreg_q     <= 8'h00;
      sub_addr_q  <= 8'h00;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      bit_cnt_q   <= 4'd0;
      bit_pend_q  <= 1'b0;
      drive_en_q  <= 1'b0;
      drive_val_q <= 1'b1;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      wr_q        <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      if (start_ev || stop_ev) begin
        abort_q     <= mid_byte;
        busy_q      <= start_ev;
        drive_en_q  <= 1'b0;
        drive_val_q <= 1'b1;
        bit_cnt_q   <= 4'd0;
        bit_pend_q  <= 1'b0;
        state_q     <= start_ev ? StId : StIdle;
      end else begin
        case (state_q)
          StId, StSub, StWdata: begin
            // A bit counts once its high phase completes, so a trailing STOP or
            // repeated-START clock rise does not look like a partial byte.
            if (scl_rise) begin
              shreg_q    <= shreg_in;
              bit_pend_q <= 1'b1;
              if ((state_q == StWdata) && (bit_cnt_q == 4'd7)) begin
                regs_q[sub_addr_q] <= shreg_in;
                wr_q               <= 1'b1;
                wr_addr_q          <= sub_addr_q;
                wr_data_q          <= shreg_in;
              end
            end else if (scl_fall && bit_pend_q) begin
              bit_pend_q <= 1'b0;
              if (bit_cnt_q != 4'd7) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end else begin
                bit_cnt_q   <= 4'd0;
                drive_en_q  <= 1'b1;
                drive_val_q <= 1'b0;
                case (state_q)
                  StId: begin
                    if (shreg_q[7:1] == DEVICE_ID[7:1]) begin
                      state_q <= StIdAck;
                    end else begin
                      drive_en_q  <= 1'b0;
                      drive_val_q <= 1'b1;
                      state_q     <= StIgnore;
                    end
                  end
                  StSub: begin
                    sub_addr_q <= shreg_q;
                    state_q    <= StSubAck;
                  end
                  default: state_q <= StWdataAck;
                endcase
              end
            end
          end
          StIdAck: begin
            if (scl_fall) begin
              if (shreg_q[0]) begin
                shreg_q     <= regs_q[sub_addr_q];
                drive_val_q <= regs_q[sub_addr_q][7];
                bit_cnt_q   <= 4'd1;
                state_q     <= StRdata;
              end else begin
                drive_en_q  <= 1'b0;
                drive_val_q <= 1'b1;
                state_q     <= StSub;
              end
            end
          end
          StSubAck: begin
            if (scl_fall) begin
              drive_en_q  <= 1'b0;
              drive_val_q <= 1'b1;
              state_q     <= StWdata;
            end
          end
          StWdataAck: begin
            if (scl_fall) begin
              drive_en_q  <= 1'b0;
              drive_val_q <= 1'b1;
              state_q     <= StIgnore;
            end
          end
          StRdata: begin
            // bit_cnt_q counts bits already placed on the line.
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                drive_en_q  <= 1'b0;
                drive_val_q <= 1'b1;
                bit_cnt_q   <= 4'd0;
                state_q     <= StRdNa;
              end else begin
                drive_val_q <= shreg_q[6];
                shreg_q     <= {shreg_q[6:0], 1'b0};
                bit_cnt_q   <= bit_cnt_q + 4'd1;
              end
            end
          end
          StRdNa: begin
            if (scl_rise) begin
              state_q <= StIgnore;
            end
          end
          StIdle, StIgnore: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign siod             = drive_en_q ? drive_val_q : 1'bz;
  assign host.host_rdata  = regs_q[host.host_addr];
  assign host.reg_wr      = wr_q;
  assign host.reg_wr_addr = wr_addr_q;
  assign host.reg_wr_data = wr_data_q;
  assign host.sub_addr    = sub_addr_q;
  assign host.busy        = busy_q;
  assign host.txn_abort   = abort_q;

endmodule
